// File: rtl/ez8_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Address and data widths match the CPU's instruction-memory write port.
package ez8_loader_pkg;

  localparam int IADDR_W = 12;
  localparam int IDATA_W = 16;

  localparam logic [15:0] MAX_WORDS         = 16'd4096;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CHECK,
    RESTART,
    ERR
  } loader_state_e;

  function automatic logic count_legal(input logic [15:0] n);
    return (n != 16'd0) && (n <= MAX_WORDS);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled and
// reports expiry once the full budget of idle clocks has elapsed.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = LOAD_VAL;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= LOAD_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/instr_loader.sv
// Framed byte-stream loader: assembles big-endian words into instruction
// memory while the CPU is paused, verifies a checksum, then restarts the CPU.
module instr_loader
  import ez8_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned RESET_CYCLES   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [IADDR_W-1:0] instr_writeaddr,
  output logic [IDATA_W-1:0] instr_writedata,
  output logic               instr_write_en,
  output logic               cpu_pause,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

  loader_state_e      state_q, state_d;
  logic [IADDR_W-1:0] addr_q, addr_d;
  logic [IDATA_W-1:0] data_q, data_d;
  logic [IADDR_W:0]   remaining_q, remaining_d;
  logic [7:0]         sum_q, sum_d;
  logic [7:0]         cnt_hi_q, cnt_hi_d;
  logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic               rx_ready_q, rx_ready_d;
  logic               we_q, we_d;
  logic               pause_q, pause_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic        accept;
  logic        is_sync;
  logic        timer_enable;
  logic        timed_out;
  logic [15:0] count_n;

  assign accept       = rx_valid && rx_ready_q;
  assign is_sync      = (rx_data == SYNC_BYTE);
  assign count_n      = {cnt_hi_q, rx_data};
  assign timer_enable = (state_q != IDLE) && (state_q != RESTART) && (state_q != ERR);

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (timer_enable),
    .expired(timed_out)
  );

  // An accepted byte is always handled before the timeout, so a byte that
  // lands on the expiry cycle keeps the frame alive.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    remaining_d = remaining_q;
    sum_d       = sum_q;
    cnt_hi_d    = cnt_hi_q;
    rst_cnt_d   = rst_cnt_q;
    pause_d     = pause_q;
    busy_d      = busy_q;
    error_d     = error_q;
    we_d        = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE, ERR: begin
        if (accept && is_sync) begin
          sum_d   = 8'd0;
          addr_d  = '0;
          error_d = 1'b0;
          pause_d = 1'b1;
          busy_d  = 1'b1;
          state_d = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          cnt_hi_d = rx_data;
          sum_d    = sum_q + rx_data;
          state_d  = CNT_LO;
        end else if (timed_out) begin
          state_d = ERR;
        end
      end
      CNT_LO: begin
        if (accept) begin
          sum_d       = sum_q + rx_data;
          remaining_d = count_n[IADDR_W:0];
          state_d     = count_legal(count_n) ? DATA_HI : ERR;
        end else if (timed_out) begin
          state_d = ERR;
        end
      end
      DATA_HI: begin
        if (accept) begin
          data_d[15:8] = rx_data;
          sum_d        = sum_q + rx_data;
          state_d      = DATA_LO;
        end else if (timed_out) begin
          state_d = ERR;
        end
      end
      DATA_LO: begin
        if (accept) begin
          data_d[7:0] = rx_data;
          sum_d       = sum_q + rx_data;
          we_d        = 1'b1;
          state_d     = WRITE;
        end else if (timed_out) begin
          state_d = ERR;
        end
      end
      WRITE: begin
        addr_d      = addr_q + IADDR_W'(1);
        remaining_d = remaining_q - (IADDR_W + 1)'(1);
        state_d     = (remaining_q == (IADDR_W + 1)'(1)) ? CHECK : DATA_HI;
      end
      CHECK: begin
        if (accept) begin
          rst_cnt_d = '0;
          state_d   = (rx_data == sum_q) ? RESTART : ERR;
        end else if (timed_out) begin
          state_d = ERR;
        end
      end
      RESTART: begin
        if (rst_cnt_q == RC_LAST) begin
          pause_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Memory may already be partly overwritten, so the CPU stays paused in ERR.
    if (state_d == ERR) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
    end

    rx_ready_d  = (state_d != WRITE) && (state_d != RESTART);
    cpu_reset_d = (state_d == RESTART);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      remaining_q <= '0;
      sum_q       <= 8'd0;
      cnt_hi_q    <= 8'd0;
      rst_cnt_q   <= '0;
      rx_ready_q  <= 1'b1;
      we_q        <= 1'b0;
      pause_q     <= 1'b0;
      cpu_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      remaining_q <= remaining_d;
      sum_q       <= sum_d;
      cnt_hi_q    <= cnt_hi_d;
      rst_cnt_q   <= rst_cnt_d;
      rx_ready_q  <= rx_ready_d;
      we_q        <= we_d;
      pause_q     <= pause_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rx_ready        = rx_ready_q;
  assign instr_writeaddr = addr_q;
  assign instr_writedata = data_q;
  assign instr_write_en  = we_q;
  assign cpu_pause       = pause_q;
  assign cpu_reset       = cpu_reset_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule
